// File: rtl/noc_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_router_pkg
// Description : Shared constants, types and the XY route function for the
//               5-port mesh NoC router.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_router_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 8;

    typedef logic [2:0]        port_idx_t;
    typedef logic [FLIT_W-1:0] flit_t;

    // Port indices; this order is also the round-robin index order
    localparam port_idx_t LOCAL = 3'd0;
    localparam port_idx_t NORTH = 3'd1;
    localparam port_idx_t SOUTH = 3'd2;
    localparam port_idx_t EAST  = 3'd3;
    localparam port_idx_t WEST  = 3'd4;

    // Flit field positions
    localparam int DEST_X_MSB  = 7;
    localparam int DEST_X_LSB  = 6;
    localparam int DEST_Y_MSB  = 5;
    localparam int DEST_Y_LSB  = 4;
    localparam int PAYLOAD_MSB = 3;
    localparam int PAYLOAD_LSB = 0;

    // Dimension-order routing: resolve X first, then Y, else deliver locally
    function automatic port_idx_t xy_route(input flit_t f,
                                           input logic [1:0] rx,
                                           input logic [1:0] ry);
        logic [1:0] dx;
        logic [1:0] dy;
        dx = f[DEST_X_MSB:DEST_X_LSB];
        dy = f[DEST_Y_MSB:DEST_Y_LSB];
        if (dx > rx)      return EAST;
        else if (dx < rx) return WEST;
        else if (dy > ry) return NORTH;
        else if (dy < ry) return SOUTH;
        else              return LOCAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_router_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_rr_arbiter
// Description : 5-requester round-robin arbiter, one-hot grant. Priority
//               moves to the index after the last granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_rr_arbiter
    import noc_router_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_en,
    output logic [NUM_PORTS-1:0] o_grant
);

    port_idx_t r_ptr;
    port_idx_t w_next_ptr;
    logic      w_found;
    int        w_j;

    // Scan requesters starting at the pointer and grant the first one found
    always_comb begin
        o_grant    = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        w_j        = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= NUM_PORTS) w_j = w_j - NUM_PORTS;
            if (!w_found && i_en && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                w_found      = 1'b1;
                w_next_ptr   = (w_j == NUM_PORTS - 1) ? port_idx_t'(0)
                                                      : port_idx_t'(w_j + 1);
            end
        end
    end

    // Pointer advances only when a grant is actually issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_ptr <= '0;
        else if (w_found) r_ptr <= w_next_ptr;
    end

endmodule
`default_nettype wire

// File: rtl/noc_router.sv
`default_nettype none
// ============================================================================
// Module      : noc_router
// Description : 5-port mesh NoC router, single-flit 8-bit packets, XY
//               routing, one-entry input buffers, registered outputs and a
//               round-robin arbiter per output.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_router
    import noc_router_pkg::*;
#(
    parameter int ROUTER_X = 1,
    parameter int ROUTER_Y = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in_local,
    input  logic       valid_in_local,
    output logic       ready_out_local,
    input  logic [7:0] data_in_north,
    input  logic       valid_in_north,
    output logic       ready_out_north,
    input  logic [7:0] data_in_south,
    input  logic       valid_in_south,
    output logic       ready_out_south,
    input  logic [7:0] data_in_east,
    input  logic       valid_in_east,
    output logic       ready_out_east,
    input  logic [7:0] data_in_west,
    input  logic       valid_in_west,
    output logic       ready_out_west,
    output logic [7:0] data_out_local,
    output logic       valid_out_local,
    input  logic       ready_in_local,
    output logic [7:0] data_out_north,
    output logic       valid_out_north,
    input  logic       ready_in_north,
    output logic [7:0] data_out_south,
    output logic       valid_out_south,
    input  logic       ready_in_south,
    output logic [7:0] data_out_east,
    output logic       valid_out_east,
    input  logic       ready_in_east,
    output logic [7:0] data_out_west,
    output logic       valid_out_west,
    input  logic       ready_in_west
);

    localparam logic [1:0] c_ROUTER_X = 2'(ROUTER_X);
    localparam logic [1:0] c_ROUTER_Y = 2'(ROUTER_Y);

    flit_t                w_din [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_vin;
    logic [NUM_PORTS-1:0] w_rin;
    logic [NUM_PORTS-1:0] w_rdy;

    flit_t                r_buf [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_buf_v;
    flit_t                r_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_vout;

    port_idx_t            w_route [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_req   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_gnt   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_out_free;
    logic [NUM_PORTS-1:0] w_in_gnt;
    logic [NUM_PORTS-1:0] w_out_load;
    flit_t                w_gdata [NUM_PORTS];

    assign w_din[LOCAL] = data_in_local;
    assign w_din[NORTH] = data_in_north;
    assign w_din[SOUTH] = data_in_south;
    assign w_din[EAST]  = data_in_east;
    assign w_din[WEST]  = data_in_west;
    assign w_vin = {valid_in_west, valid_in_east, valid_in_south, valid_in_north, valid_in_local};
    assign w_rin = {ready_in_west, ready_in_east, ready_in_south, ready_in_north, ready_in_local};

    assign {ready_out_west, ready_out_east, ready_out_south, ready_out_north, ready_out_local} = w_rdy;
    assign {valid_out_west, valid_out_east, valid_out_south, valid_out_north, valid_out_local} = r_vout;
    assign data_out_local = r_dout[LOCAL];
    assign data_out_north = r_dout[NORTH];
    assign data_out_south = r_dout[SOUTH];
    assign data_out_east  = r_dout[EAST];
    assign data_out_west  = r_dout[WEST];

    // Route each buffered flit and build per-output request vectors
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_route[i] = xy_route(r_buf[i], c_ROUTER_X, c_ROUTER_Y);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_out_free[o] = !r_vout[o] || w_rin[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_req[o][i] = r_buf_v[i] && (w_route[i] == port_idx_t'(o));
            end
        end
    end

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
            noc_rr_arbiter u_arb (
                .clk     (clk),
                .rst     (rst),
                .i_req   (w_req[o]),
                .i_en    (w_out_free[o]),
                .o_grant (w_gnt[o])
            );
        end
    endgenerate

    // Collect grants per input and mux the granted flit onto each output
    always_comb begin
        w_in_gnt = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_gdata[o]    = '0;
            w_out_load[o] = |w_gnt[o];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_gnt[o][i]) begin
                    w_gdata[o]  = w_gdata[o] | r_buf[i];
                    w_in_gnt[i] = 1'b1;
                end
            end
        end
        w_rdy = ~r_buf_v | w_in_gnt;
    end

    // Input buffers: capture on handshake, free when granted and not refilled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_v <= '0;
            for (int i = 0; i < NUM_PORTS; i++) r_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_vin[i] && w_rdy[i]) begin
                    r_buf[i]   <= w_din[i];
                    r_buf_v[i] <= 1'b1;
                end else if (w_in_gnt[i]) begin
                    r_buf_v[i] <= 1'b0;
                end
            end
        end
    end

    // Output registers: load on grant, hold while stalled, clear on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vout <= '0;
            for (int o = 0; o < NUM_PORTS; o++) r_dout[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (w_out_load[o]) begin
                    r_dout[o] <= w_gdata[o];
                    r_vout[o] <= 1'b1;
                end else if (w_rin[o]) begin
                    r_vout[o] <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_noc_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_router
// Description : Directed self-checking bench for noc_router at tile (1,1)
//               with a flit scoreboard keyed by output port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_router;

    localparam int P_L = 0, P_N = 1, P_S = 2, P_E = 3, P_W = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din  [5];
    logic [7:0] dout [5];
    logic [4:0] vin, rin, rdy, vout;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [2:0] port;
        logic [7:0] data;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    noc_router #(.ROUTER_X(1), .ROUTER_Y(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in_local   (din[0]), .valid_in_local (vin[0]), .ready_out_local (rdy[0]),
        .data_in_north   (din[1]), .valid_in_north (vin[1]), .ready_out_north (rdy[1]),
        .data_in_south   (din[2]), .valid_in_south (vin[2]), .ready_out_south (rdy[2]),
        .data_in_east    (din[3]), .valid_in_east  (vin[3]), .ready_out_east  (rdy[3]),
        .data_in_west    (din[4]), .valid_in_west  (vin[4]), .ready_out_west  (rdy[4]),
        .data_out_local  (dout[0]), .valid_out_local (vout[0]), .ready_in_local (rin[0]),
        .data_out_north  (dout[1]), .valid_out_north (vout[1]), .ready_in_north (rin[1]),
        .data_out_south  (dout[2]), .valid_out_south (vout[2]), .ready_in_south (rin[2]),
        .data_out_east   (dout[3]), .valid_out_east  (vout[3]), .ready_in_east  (rin[3]),
        .data_out_west   (dout[4]), .valid_out_west  (vout[4]), .ready_in_west  (rin[4])
    );

    // Reference XY routing for a router at (1,1)
    function automatic int ref_route(input logic [7:0] f);
        logic [1:0] x, y;
        x = f[7:6];
        y = f[5:4];
        if (x > 2'd1) return P_E;
        if (x < 2'd1) return P_W;
        if (y > 2'd1) return P_N;
        if (y < 2'd1) return P_S;
        return P_L;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Remove a matching flit for this output from the scoreboard
    task automatic sb_take(input int o, input logic [7:0] d);
        int idx;
        idx = -1;
        for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].port == 3'(o) && sbq[k].data == d) idx = k;
        checks++;
        assert ((idx >= 0) === 1'b1) else begin
            fails++;
            $error("FAIL sb_out%0d: observed=%h expected=a queued flit for this output", o, d);
        end
        if (idx >= 0) sbq.delete(idx);
    endtask

    // One clock: score transfers/acceptances before the edge, retire accepted
    // inputs after it, return at the following falling edge
    task automatic cycle();
        logic [4:0] acc;
        #1;
        for (int o = 0; o < 5; o++)
            if (vout[o] && rin[o]) sb_take(o, dout[o]);
        acc = vin & rdy;
        for (int i = 0; i < 5; i++)
            if (acc[i]) sbq.push_back('{port: 3'(ref_route(din[i])), data: din[i]});
        @(posedge clk);
        #1;
        vin = vin & ~acc;
        @(negedge clk);
    endtask

    task automatic chk_only(input string tag, input int o, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(vout), 32'(5'b1 << o));
        chk({tag, "_data"}, 32'(dout[o]), 32'(d));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] dir_data [4];
    int         dir_port [4];

    initial begin
        for (int i = 0; i < 5; i++) din[i] = 8'h00;
        vin = '0;
        rin = 5'b11111;
        dir_data = '{8'h1F, 8'h6F, 8'h4F, 8'h5A};
        dir_port = '{P_W, P_N, P_S, P_L};

        // Reset state, during and after rst
        #3;
        chk("rst_vout", 32'(vout), 32'h0);
        chk("rst_dout_e", 32'(dout[P_E]), 32'h0);
        chk("rst_rdy", 32'(rdy), 32'h1F);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vout", 32'(vout), 32'h0);
        chk("post_rst_rdy", 32'(rdy), 32'h1F);
        for (int i = 0; i < 5; i++) chk("post_rst_dout", 32'(dout[i]), 32'h0);

        // Contention from fresh pointers: local wins first
        din[P_L] = 8'hA5; vin[P_L] = 1'b1;
        din[P_N] = 8'h9F; vin[P_N] = 1'b1;
        cycle();
        chk("cont_lat", 32'(vout), 32'h0);
        // Local refills while its A5 is granted; north's 9F is still waiting
        din[P_L] = 8'hA6; vin[P_L] = 1'b1;
        cycle();
        chk_only("cont1_a5", P_E, 8'hA5);
        cycle();
        chk_only("cont1_9f", P_E, 8'h9F);
        cycle();
        chk_only("cont1_a6", P_E, 8'hA6);
        // Pointer now sits on north: simultaneous requests go north first
        din[P_L] = 8'hA7; vin[P_L] = 1'b1;
        din[P_N] = 8'h8C; vin[P_N] = 1'b1;
        cycle();
        cycle();
        chk_only("cont2_north", P_E, 8'h8C);
        cycle();
        chk_only("cont2_local", P_E, 8'hA7);
        cycle();
        chk("cont_idle", 32'(vout), 32'h0);

        // Single flit local -> east, one-cycle latency, one-cycle pulse
        din[P_L] = 8'h9F; vin[P_L] = 1'b1;
        cycle();
        chk("east_lat0", 32'(vout), 32'h0);
        cycle();
        chk_only("east", P_E, 8'h9F);
        cycle();
        chk("east_pulse", 32'(vout), 32'h0);

        // Directional routing from local
        for (int t = 0; t < 4; t++) begin
            din[P_L] = dir_data[t]; vin[P_L] = 1'b1;
            cycle();
            cycle();
            chk_only($sformatf("dir%0d", t), dir_port[t], dir_data[t]);
        end
        cycle();
        chk("dir_idle", 32'(vout), 32'h0);

        // Backpressure on east
        rin[P_E] = 1'b0;
        din[P_L] = 8'h9F; vin[P_L] = 1'b1;
        cycle();
        din[P_L] = 8'hA3; vin[P_L] = 1'b1;
        cycle();
        chk_only("bp_hold0", P_E, 8'h9F);
        chk("bp_rdy0", 32'(rdy[P_L]), 32'h0);
        cycle();
        chk_only("bp_hold1", P_E, 8'h9F);
        chk("bp_rdy1", 32'(rdy[P_L]), 32'h0);
        rin[P_E] = 1'b1;
        cycle();
        chk_only("bp_a3", P_E, 8'hA3);
        chk("bp_rdy_free", 32'(rdy[P_L]), 32'h1);
        cycle();
        chk("bp_idle", 32'(vout), 32'h0);

        // Asynchronous reset while east is presenting a flit
        din[P_L] = 8'h9F; vin[P_L] = 1'b1;
        cycle();
        din[P_L] = 8'hA3; vin[P_L] = 1'b1;
        cycle();
        chk_only("ar_pre", P_E, 8'h9F);
        #2 rst = 1'b1;
        #1;
        chk("ar_vout", 32'(vout), 32'h0);
        chk("ar_dout", 32'(dout[P_E]), 32'h0);
        chk("ar_rdy", 32'(rdy), 32'h1F);
        vin = '0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("ar_quiet", 32'(vout), 32'h0);
        end

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_router.md
Name: noc_router

Overview:
- 5-port mesh NoC router: local, north, south, east and west ports.
- Moves single-flit 8-bit packets using deterministic XY (dimension-order) routing.
- Every port uses a valid/ready handshake.
- One instance per mesh tile; the local port connects to the tile's processing element.

Parameters:
- ROUTER_X, 1, this router's X coordinate (2-bit).
- ROUTER_Y, 1, this router's Y coordinate (2-bit).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- Per input direction d in {local, north, south, east, west}:
  - `data_in_<d>` in 8: incoming flit.
  - `valid_in_<d>` in 1: flit on `data_in_<d>` is valid.
  - `ready_out_<d>` out 1: router can accept a flit on this input this cycle.
- Per output direction d in {local, north, south, east, west}:
  - `data_out_<d>` out 8: outgoing flit.
  - `valid_out_<d>` out 1: flit on `data_out_<d>` is valid.
  - `ready_in_<d>` in 1: downstream accepts the flit this cycle.

Behaviour:
- Flit format:
  - [7:6] dest_x.
  - [5:4] dest_y.
  - [3:0] payload.
  - Forwarded unmodified.
- Routing (XY), unsigned compares, evaluated in this order:
  - dest_x > ROUTER_X -> east.
  - dest_x < ROUTER_X -> west.
  - Otherwise dest_y > ROUTER_Y -> north.
  - Otherwise dest_y < ROUTER_Y -> south.
  - Otherwise local.
  - Routing applies regardless of arrival port; U-turns are permitted.
- Input stage: one-entry buffer per input.
  - `ready_out_<d>` = buffer empty OR buffer granted this cycle (combinational).
  - Flit is captured when `valid_in` AND `ready_out` are high at a rising edge.
- Arbitration: one round-robin arbiter per output.
  - Requesters are the occupied input buffers routed to that output.
  - Priority rotates to the index after the last granted input.
  - Index order: local=0, north=1, south=2, east=3, west=4.
  - Pointer reset value is 0 (local highest).
  - A grant is issued only when the output register is empty or draining (`valid_out` AND `ready_in`).
- Output stage: one register per output.
  - Loaded with the granted flit; `valid_out` set.
  - Holds data and `valid_out` stable while `valid_out`=1 and `ready_in`=0.
  - Clears `valid_out` on transfer with no new grant.
- Latency:
  - Flit accepted at edge N appears on `data_out` with `valid_out`=1 after edge N+1.
  - Throughput is one flit per cycle per output.
- Simultaneous events:
  - A buffer drained and refilled in the same cycle is legal.
  - An output drained and reloaded in the same cycle is legal (back-to-back flits).
- Reset, async, mid-operation included:
  - All `valid_out`=0, all `data_out`=8'h00.
  - All buffers empty, so all `ready_out`=1.
  - Arbiter pointers = 0.
  - In-flight flits are dropped.
- Flits are never duplicated or reordered per input-output pair.

Decomposition:
- Shared package `noc_router_pkg`:
  - Port index constants (LOCAL..WEST) and NUM_PORTS=5.
  - FLIT_W=8.
  - Field bit positions for dest_x, dest_y and payload.
  - XY route function.
- Sub-module `noc_rr_arbiter`: 5 requesters, one-hot grant, advance-on-grant; instantiated once per output.

Test Plan:
- Reset with all `valid_in`=0:
  - All `valid_out`=0 and `data_out`=00.
  - All `ready_out`=1 (checked during and after `rst`).
- Local injects 8'h9F (dest 2,1) for one cycle at router (1,1):
  - `valid_out_east`=1 with `data_out_east`=9F one cycle after acceptance, for exactly one cycle.
  - All other outputs idle.
- Directional routing from local:
  - 8'h1F -> west.
  - 8'h6F -> north.
  - 8'h4F -> south.
  - 8'h5A -> `data_out_local`=5A.
  - Each with 1-cycle latency.
- Backpressure:
  - Setup: `ready_in_east`=0; local sends 9F then A3.
  - East holds 9F stable; A3 stays buffered; `ready_out_local`=0.
  - Raise `ready_in_east`: 9F then A3 on consecutive cycles, then `ready_out_local`=1.
- Contention: local sends A5 and north sends 9F in the same cycle, both to east.
  - Cycle after: east outputs A5 (local wins, pointer 0).
  - Next cycle: east outputs 9F.
  - Repeat: north wins.
- Async reset mid-flight:
  - Assert `rst` between clock edges while `valid_out_east`=1.
  - `valid_out_east` drops immediately without a clock edge.
  - Nothing is emitted after release.
